microsequencer_param: RTL and testbench
=======================================

// Module: microsequencer_param
// PURPOSE
//  Parametrised microprogram sequencer for the ARM datapath control unit: computes the next microaddress, fetches the
//  microword from an external combinational ROM and registers it. Drives the registered control field to the datapath.
//  Adds a micro-subroutine stack (CALL/RET), a pipeline STALL, and widths set by parameters instead of fixed values.
// PARAMETERS
//  AW           8   microaddress width (ROM depth 2**AW)
//  CW_W         34  control-field width (datapath control bits)
//  NCOND        8   number of condition inputs (power of 2, >=2); CSW=$clog2(NCOND) is derived
//  STACK_DEPTH  4   micro-stack entries (>=1)
//  Derived UW = 3+1+CSW+AW+CW_W. Microword layout MSB->LSB: OP[2:0] | INV | CSEL[CSW-1:0] | TARGET[AW-1:0] | CTRL[CW_W-1:0]
// PORTS
//  CLK            in   1        rising-edge clock
//  RST_N          in   1        synchronous reset, active low
//  STALL          in   1        1 = freeze all sequencer state this cycle
//  COND           in   NCOND    condition inputs (MOC, COND, IR bits, LSM flags...)
//  DISPATCH_ADDR  in   AW       opcode-decoded entry address from the instruction encoder
//  UWORD          in   UW       ROM data for UADDR (combinational read)
//  UADDR          out  AW       next microaddress (combinational from registered state)
//  CU             out  CW_W     CTRL field of the current microword (registered)
//  UPC            out  AW       address of the current microword (registered)
//  STK_ERR        out  1        sticky micro-stack overflow/underflow flag
// BEHAVIOUR
//  - Reset (RST_N=0 at edge): microword reg <= 0, UPC <= 0, SP <= 0, STK_ERR <= 0. CU=0 after that edge.
//    All-zero word decodes as RESTART, so the first edge with RST_N=1 loads ROM[0], UPC=0. Reset overrides STALL.
//  - Each edge, RST_N=1, STALL=0: microword reg <= UWORD, UPC <= UADDR, stack updates per OP. Latency: UADDR->CU 1 cycle.
//  - STALL=1: microword reg, UPC, SP, stack and STK_ERR hold; UADDR still driven but not consumed.
//  - c = COND[CSEL] ^ INV. inc = UPC+1 mod 2**AW (wraps 2**AW-1 -> 0).
//  - OP decode (current registered word) -> UADDR:
//    000 RESTART  0            001 CONT  inc            010 JUMP   TARGET         011 CBR  c ? TARGET : inc
//    100 DISPATCH DISPATCH_ADDR                         101 CDISP  c ? DISPATCH_ADDR : inc
//    110 CALL     TARGET; push inc                      111 RET    top of stack; pop
//  - Stack full on CALL: no push, jump still taken, STK_ERR <= 1. Empty on RET: UADDR=0, SP unchanged, STK_ERR <= 1.
//  - STK_ERR clears only on reset. Stack contents are not reset, only SP.
//  - No CU glitch: CU changes only at CLK rising edges.
// CONFIGURATION
//  - `define MICROSEQ_STACK_EN: stack present, CALL/RET as above.
//  - Without it: no stack storage; CALL behaves as JUMP (no push), RET as RESTART; STK_ERR tied 0.
// STRUCTURE
//  - Package microseq_pkg: OP_* localparams (3-bit encodings above), field-offset functions of (AW,CSW,CW_W), UW calc.
//  - Sub-module microseq_stack (LIFO, params AW, STACK_DEPTH; push/pop/full/empty/top; sync active-low reset of SP).
//    Instantiated only under MICROSEQ_STACK_EN.
//  - Top: next-address mux, condition select/invert, incrementer, microword/UPC registers.
// TESTING (AW=8, CW_W=34, NCOND=8, STACK_DEPTH=4, macro defined unless stated)
//  1 Reset: hold RST_N=0 2 cycles with STALL=1 -> CU=0, UPC=0, UADDR=0; release -> next edge UPC=0, CU=ROM[0].CTRL.
//  2 CBR: ROM[5]={CBR,INV=0,CSEL=2,TGT=0x40}; COND[2]=1 -> UPC 0x40 next; COND[2]=0 -> 0x06; INV=1 reverses both.
//  3 Dispatch+wrap: ROM[0xFF]=CONT -> next UPC=0x00; DISPATCH with DISPATCH_ADDR=0x80 -> UPC=0x80.
//  4 Nesting: CALL 0x10 at 0x03, CALL 0x20 at 0x10, RET, RET -> UPC 0x10,0x20,0x11,0x04; STK_ERR=0.
//  5 Errors: 5 nested CALLs -> 5th jumps but STK_ERR=1; RET on empty -> UPC=0, STK_ERR stays 1 until reset.
//  6 STALL mid-CALL: STALL=1 for 3 cycles while CALL is current -> UPC, CU, SP unchanged; release -> push once only.
//    Rerun 4 without macro -> UPC 0x10,0x20,0x00, STK_ERR=0.

Source files
------------

// File: rtl/microseq_pkg.sv
// rtl/microseq_pkg.sv - microsequencer opcodes and microword field layout helpers
package microseq_pkg;

  localparam logic [2:0] OP_RESTART  = 3'b000;
  localparam logic [2:0] OP_CONT     = 3'b001;
  localparam logic [2:0] OP_JUMP     = 3'b010;
  localparam logic [2:0] OP_CBR      = 3'b011;
  localparam logic [2:0] OP_DISPATCH = 3'b100;
  localparam logic [2:0] OP_CDISP    = 3'b101;
  localparam logic [2:0] OP_CALL     = 3'b110;
  localparam logic [2:0] OP_RET      = 3'b111;

  // Layout MSB->LSB: OP[2:0] | INV | CSEL | TARGET | CTRL
  function automatic int uw_calc(input int aw, input int csw, input int cw_w);
    return 3 + 1 + csw + aw + cw_w;
  endfunction

  function automatic int tgt_lsb(input int cw_w);
    return cw_w;
  endfunction

  function automatic int csel_lsb(input int aw, input int cw_w);
    return aw + cw_w;
  endfunction

  function automatic int inv_bit(input int aw, input int csw, input int cw_w);
    return csw + aw + cw_w;
  endfunction

  function automatic int op_lsb(input int aw, input int csw, input int cw_w);
    return inv_bit(aw, csw, cw_w) + 1;
  endfunction

endpackage

// File: rtl/microseq_stack.sv
// rtl/microseq_stack.sv - micro-subroutine return-address LIFO (used when MICROSEQ_STACK_EN is defined)
module microseq_stack #(
  parameter int AW          = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] top
);

  localparam int PW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [AW-1:0] mem [STACK_DEPTH];
  logic [PW-1:0] sp;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  assign full   = (sp == PW'(STACK_DEPTH));
  assign empty  = (sp == '0);
  assign wr_idx = IW'(sp);
  assign rd_idx = IW'(sp - PW'(1));
  assign top    = mem[rd_idx];

  // Contents are deliberately left unreset; only the pointer defines validity.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + PW'(1);
    end else if (pop && !empty) begin
      sp <= sp - PW'(1);
    end
  end

endmodule

// File: rtl/microsequencer_param.sv
// rtl/microsequencer_param.sv - parametrised microprogram sequencer; CALL/RET stack enabled by MICROSEQ_STACK_EN
module microsequencer_param
  import microseq_pkg::*;
#(
  parameter int AW          = 8,
  parameter int CW_W        = 34,
  parameter int NCOND       = 8,
  parameter int STACK_DEPTH = 4,
  localparam int CSW        = $clog2(NCOND),
  localparam int UW         = uw_calc(AW, CSW, CW_W)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             STALL,
  input  logic [NCOND-1:0] COND,
  input  logic [AW-1:0]    DISPATCH_ADDR,
  input  logic [UW-1:0]    UWORD,
  output logic [AW-1:0]    UADDR,
  output logic [CW_W-1:0]  CU,
  output logic [AW-1:0]    UPC,
  output logic             STK_ERR
);

  localparam int OP_LSB   = op_lsb(AW, CSW, CW_W);
  localparam int INV_BIT  = inv_bit(AW, CSW, CW_W);
  localparam int CSEL_LSB = csel_lsb(AW, CW_W);
  localparam int TGT_LSB  = tgt_lsb(CW_W);

  logic [UW-1:0]  uword_q;
  logic [AW-1:0]  upc_q;
  logic [AW-1:0]  upc_inc;
  logic [AW-1:0]  target;
  logic [2:0]     op;
  logic [CSW-1:0] csel;
  logic           inv;
  logic           cond_hit;

  assign op       = uword_q[OP_LSB +: 3];
  assign inv      = uword_q[INV_BIT];
  assign csel     = uword_q[CSEL_LSB +: CSW];
  assign target   = uword_q[TGT_LSB +: AW];
  assign cond_hit = COND[csel] ^ inv;
  assign upc_inc  = upc_q + AW'(1);

`ifdef MICROSEQ_STACK_EN
  logic          stk_push;
  logic          stk_pop;
  logic          stk_full;
  logic          stk_empty;
  logic          stk_err_q;
  logic [AW-1:0] stk_top;

  // Stack only moves on cycles where the current microword is actually retired.
  assign stk_push = RST_N && !STALL && (op == OP_CALL);
  assign stk_pop  = RST_N && !STALL && (op == OP_RET);

  microseq_stack #(
    .AW          (AW),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (CLK),
    .resetn    (RST_N),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (upc_inc),
    .full      (stk_full),
    .empty     (stk_empty),
    .top       (stk_top)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stk_err_q <= 1'b0;
    end else if ((stk_push && stk_full) || (stk_pop && stk_empty)) begin
      stk_err_q <= 1'b1;
    end
  end

  assign STK_ERR = stk_err_q;
`else
  logic unused_stack_depth;
  assign unused_stack_depth = ^32'(STACK_DEPTH);
  assign STK_ERR = 1'b0;
`endif

  always_comb begin
    UADDR = '0;
    case (op)
      OP_RESTART:  UADDR = '0;
      OP_CONT:     UADDR = upc_inc;
      OP_JUMP:     UADDR = target;
      OP_CBR:      UADDR = cond_hit ? target : upc_inc;
      OP_DISPATCH: UADDR = DISPATCH_ADDR;
      OP_CDISP:    UADDR = cond_hit ? DISPATCH_ADDR : upc_inc;
      OP_CALL:     UADDR = target;
`ifdef MICROSEQ_STACK_EN
      OP_RET:      UADDR = stk_empty ? '0 : stk_top;
`else
      OP_RET:      UADDR = '0;
`endif
      default:     UADDR = '0;
    endcase
  end

  // An all-zero word decodes as RESTART, so reset naturally fetches ROM[0] next.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      uword_q <= '0;
      upc_q   <= '0;
    end else if (!STALL) begin
      uword_q <= UWORD;
      upc_q   <= UADDR;
    end
  end

  assign CU  = uword_q[CW_W-1:0];
  assign UPC = upc_q;

endmodule

// File: tb/tb_microsequencer_param.sv
// tb/tb_microsequencer_param.sv - randomized and directed check of microsequencer_param against a behavioural model
module tb_microsequencer_param;

  localparam int AW    = 8;
  localparam int CW_W  = 34;
  localparam int NCOND = 8;
  localparam int SD    = 4;
  localparam int CSW   = 3;
  localparam int UW    = 3 + 1 + CSW + AW + CW_W;

  logic             clk;
  logic             rst_n;
  logic             stall;
  logic [NCOND-1:0] cond;
  logic [AW-1:0]    dispatch_addr;
  logic [UW-1:0]    uword;
  logic [AW-1:0]    uaddr;
  logic [CW_W-1:0]  cu;
  logic [AW-1:0]    upc;
  logic             stk_err;

  logic [UW-1:0] rom [256];

  microsequencer_param #(
    .AW          (AW),
    .CW_W        (CW_W),
    .NCOND       (NCOND),
    .STACK_DEPTH (SD)
  ) dut (
    .CLK           (clk),
    .RST_N         (rst_n),
    .STALL         (stall),
    .COND          (cond),
    .DISPATCH_ADDR (dispatch_addr),
    .UWORD         (uword),
    .UADDR         (uaddr),
    .CU            (cu),
    .UPC           (upc),
    .STK_ERR       (stk_err)
  );

  assign uword = rom[uaddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: current microword, its address, a return-address queue and the error flag.
  logic [UW-1:0] m_word;
  logic [AW-1:0] m_upc;
  logic          m_err;
  bit            m_valid = 0;
  int            m_stk [$];

  function automatic int fld(input int lsb, input int w);
    logic [63:0] w64;
    w64 = 64'(m_word);
    return int'((w64 >> lsb) & ((64'd1 << w) - 64'd1));
  endfunction

  function automatic logic [AW-1:0] model_next();
    int op, inv, csel, tgt, inc;
    bit c;
    op   = fld(UW - 3, 3);
    inv  = fld(UW - 4, 1);
    csel = fld(AW + CW_W, CSW);
    tgt  = fld(CW_W, AW);
    inc  = (int'(m_upc) + 1) % 256;
    c    = cond[csel] ^ inv[0];
    case (op)
      0: return '0;
      1: return AW'(inc);
      2: return AW'(tgt);
      3: return c ? AW'(tgt) : AW'(inc);
      4: return dispatch_addr;
      5: return c ? dispatch_addr : AW'(inc);
      6: return AW'(tgt);
`ifdef MICROSEQ_STACK_EN
      default: return (m_stk.size() > 0) ? AW'(m_stk[$]) : '0;
`else
      default: return '0;
`endif
    endcase
  endfunction

  task automatic model_update(input logic r, input logic s, input logic [AW-1:0] nxt);
    int op, inc;
    if (!r) begin
      m_word = '0; m_upc = '0; m_err = 1'b0; m_stk.delete(); m_valid = 1;
    end else if (!s && m_valid) begin
      op  = fld(UW - 3, 3);
      inc = (int'(m_upc) + 1) % 256;
`ifdef MICROSEQ_STACK_EN
      if (op == 6) begin
        if (m_stk.size() < SD) m_stk.push_back(inc);
        else m_err = 1'b1;
      end
      if (op == 7) begin
        if (m_stk.size() > 0) void'(m_stk.pop_back());
        else m_err = 1'b1;
      end
`endif
      m_upc  = nxt;
      m_word = rom[nxt];
    end
  endtask

  task automatic step(input logic r, input logic s);
    logic [AW-1:0] exp_addr;
    rst_n = r;
    stall = s;
    #1;
    exp_addr = model_next();
    if (m_valid) check("uaddr", 64'(uaddr), 64'(exp_addr));
    @(posedge clk);
    model_update(r, s, exp_addr);
    #1;
    check("upc", 64'(upc), 64'(m_upc));
    check("cu", 64'(cu), 64'(m_word[CW_W-1:0]));
    check("stk_err", 64'(stk_err), 64'(m_err));
    @(negedge clk);
  endtask

  function automatic logic [CW_W-1:0] rc();
    return CW_W'({$urandom, $urandom});
  endfunction

  function automatic logic [UW-1:0] mk(input int op, input int inv, input int csel, input int tgt);
    return {3'(op), 1'(inv), 3'(csel), 8'(tgt), rc()};
  endfunction

  task automatic reset_run();
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
  endtask

  bit stack_en;

  initial begin
`ifdef MICROSEQ_STACK_EN
    stack_en = 1;
`else
    stack_en = 0;
`endif
    rst_n = 1'b0; stall = 1'b0; cond = '0; dispatch_addr = '0;
    for (int i = 0; i < 256; i++) rom[i] = mk($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255));
    @(negedge clk);

    // Reset with STALL asserted, then release
    cond = 8'($urandom);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("rst_upc", 64'(upc), 64'd0);
    check("rst_cu", 64'(cu), 64'd0);
    check("rst_uaddr", 64'(uaddr), 64'd0);
    step(1'b1, 1'b0);
    check("rel_upc", 64'(upc), 64'd0);
    check("rel_cu", 64'(cu), 64'(rom[0][CW_W-1:0]));

    // Conditional branch, all INV/COND combinations
    for (int inv = 0; inv < 2; inv++) begin
      for (int cb = 0; cb < 2; cb++) begin
        rom[0]     = mk(2, 0, 0, 'h05);
        rom[5]     = mk(3, inv, 2, 'h40);
        rom[6]     = mk(1, 0, 0, 0);
        rom['h40]  = mk(1, 0, 0, 0);
        reset_run();
        step(1'b1, 1'b0);
        check("cbr_at5", 64'(upc), 64'h05);
        cond = 8'($urandom);
        cond[2] = cb[0];
        step(1'b1, 1'b0);
        check("cbr_dest", 64'(upc), ((cb ^ inv) != 0) ? 64'h40 : 64'h06);
      end
    end

    // Dispatch then wrap from 0xFF
    rom[0]     = mk(4, 0, 0, 0);
    rom['h80]  = mk(2, 0, 0, 'hFF);
    rom['hFF]  = mk(1, 0, 0, 0);
    dispatch_addr = 8'h80;
    reset_run();
    step(1'b1, 1'b0);
    check("dispatch", 64'(upc), 64'h80);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("wrap", 64'(upc), 64'h00);

    // Nested CALL/RET
    rom[0]     = mk(2, 0, 0, 'h03);
    rom[3]     = mk(6, 0, 0, 'h10);
    rom['h10]  = mk(6, 0, 0, 'h20);
    rom['h20]  = mk(7, 0, 0, 0);
    rom['h11]  = mk(7, 0, 0, 0);
    rom[4]     = mk(1, 0, 0, 0);
    reset_run();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0); check("nest0", 64'(upc), 64'h10);
    step(1'b1, 1'b0); check("nest1", 64'(upc), 64'h20);
    step(1'b1, 1'b0); check("nest2", 64'(upc), stack_en ? 64'h11 : 64'h00);
    if (stack_en) begin
      step(1'b1, 1'b0); check("nest3", 64'(upc), 64'h04);
    end
    check("nest_err", 64'(stk_err), 64'd0);

    // Overflow on the fifth nested CALL
    rom[0] = mk(2, 0, 0, 1);
    for (int i = 1; i <= 5; i++) rom[i] = mk(6, 0, 0, i + 1);
    rom[6] = mk(1, 0, 0, 0);
    rom[7] = mk(1, 0, 0, 0);
    reset_run();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    check("ovf_upc", 64'(upc), 64'd6);
    check("ovf_err", 64'(stk_err), stack_en ? 64'd1 : 64'd0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("ovf_sticky", 64'(stk_err), stack_en ? 64'd1 : 64'd0);

    // RET on empty stack
    rom[0] = mk(7, 0, 0, 0);
    reset_run();
    check("udf_pre", 64'(stk_err), 64'd0);
    step(1'b1, 1'b0);
    check("udf_upc", 64'(upc), 64'd0);
    check("udf_err", 64'(stk_err), stack_en ? 64'd1 : 64'd0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("udf_sticky", 64'(stk_err), stack_en ? 64'd1 : 64'd0);
    step(1'b0, 1'b0);
    check("udf_clr", 64'(stk_err), 64'd0);

    // STALL while CALL is the current word: exactly one push
    rom[0]    = mk(2, 0, 0, 'h03);
    rom[3]    = mk(6, 0, 0, 'h10);
    rom['h10] = mk(7, 0, 0, 0);
    rom[4]    = mk(7, 0, 0, 0);
    reset_run();
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      check("stall_upc", 64'(upc), 64'h03);
    end
    step(1'b1, 1'b0); check("stall_call", 64'(upc), 64'h10);
    step(1'b1, 1'b0); check("stall_ret", 64'(upc), stack_en ? 64'h04 : 64'h00);
    if (stack_en) begin
      step(1'b1, 1'b0);
      check("stall_once", 64'(stk_err), 64'd1);
    end

    // Random program, conditions, dispatch, stalls and occasional resets
    for (int i = 0; i < 256; i++) rom[i] = mk($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255));
    step(1'b0, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      cond = 8'($urandom);
      dispatch_addr = 8'($urandom);
      step(($urandom % 64) != 0, ($urandom % 4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
